// File: rtl/bht_ctrl.sv
// bht_ctrl - branch history table controller.
//
// Owns an array of 2-bit saturating counters indexed gshare-style
// (PC bits xor global history), the global history register (GHR) and a
// small FIFO of resolved-branch updates. Only one table access happens per
// cycle: it serves either a fetch lookup or a read-modify-write drain of
// the update queue head. After reset the table is walked once, writing
// weakly-not-taken into every entry, before any traffic is accepted.
//
// Optional feature macro: BHT_CTRL_STATS_EN adds saturating counters for
// accepted lookups and accepted mispredict updates.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   lookup_*          fetch-side prediction request (valid/ready, pc)
//   pred_*            prediction result, one cycle after acceptance
//   upd_*             resolved branch update (valid/ready, index, outcome,
//                     mispredict flag, history used at prediction time)
//   init_busy         table initialisation in progress
//   stat_*            (BHT_CTRL_STATS_EN only) lookup / mispredict counts
module bht_ctrl #(
  parameter int BHT_SIZE  = 16,
  parameter int UPQ_DEPTH = 4,
  localparam int IDX_W    = $clog2(BHT_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_index,
  output logic [IDX_W-1:0] pred_hist,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  input  logic [IDX_W-1:0] upd_hist,
  output logic             init_busy
`ifdef BHT_CTRL_STATS_EN
  ,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int CNT_W = $clog2(UPQ_DEPTH + 1);
  localparam int PTR_W = (UPQ_DEPTH > 1) ? $clog2(UPQ_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(UPQ_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(UPQ_DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_SIZE - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0] ghr_q, ghr_d, ghr_eff;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             init_busy_q, init_busy_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] pred_index_q, pred_index_d;
  logic [IDX_W-1:0] pred_hist_q, pred_hist_d;

  logic [1:0]       bht_mem [BHT_SIZE];
  logic [IDX_W-1:0] upq_idx_mem [UPQ_DEPTH];
  logic             upq_taken_mem [UPQ_DEPTH];

  logic             run, q_full, lookup_fire, upd_fire, repair, drain;
  logic [IDX_W-1:0] lookup_idx, head_idx;
  logic             head_taken;
  logic [1:0]       head_ctr, head_ctr_next;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [1:0]       tbl_wdata;

  // Only the index bits of the PC and the low history bits are consumed.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0], upd_hist[IDX_W-1]};

  always_comb begin
    run          = (state_q == ST_RUN);
    q_full       = (count_q == DEPTH_C);
    lookup_ready = run && !q_full;
    upd_ready    = run && !q_full;
    lookup_fire  = lookup_valid && lookup_ready;
    upd_fire     = upd_valid && upd_ready;
    repair       = upd_fire && upd_mispredict;
    // A full queue forces a drain; otherwise lookups own the slot and the
    // queue only drains in cycles with no accepted lookup.
    drain        = run && (q_full || (!lookup_fire && (count_q != '0)));

    // The previous prediction's outcome is folded in during its pred_valid
    // cycle, so a back-to-back lookup already sees the shifted history.
    ghr_eff    = pred_valid_q ? {ghr_q[IDX_W-2:0], pred_taken_q} : ghr_q;
    ghr_d      = repair ? {upd_hist[IDX_W-2:0], upd_taken} : ghr_eff;
    lookup_idx = lookup_pc[IDX_W+1:2] ^ ghr_eff;

    head_idx   = upq_idx_mem[rd_ptr_q];
    head_taken = upq_taken_mem[rd_ptr_q];
    head_ctr   = bht_mem[head_idx];
    if (head_taken) begin
      head_ctr_next = (head_ctr == 2'b11) ? 2'b11 : head_ctr + 2'b01;
    end else begin
      head_ctr_next = (head_ctr == 2'b00) ? 2'b00 : head_ctr - 2'b01;
    end

    // Queue bookkeeping with explicit wrap so non-power-of-two depths work.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (upd_fire) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (drain) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (upd_fire && !drain) begin
      count_d = count_q + 1'b1;
    end else if (drain && !upd_fire) begin
      count_d = count_q - 1'b1;
    end

    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
      end
    end
    init_busy_d = (state_d == ST_INIT);

    // Single table write port shared by the init walk and the drain RMW.
    tbl_we    = !reset && ((state_q == ST_INIT) || drain);
    tbl_waddr = (state_q == ST_INIT) ? init_cnt_q : head_idx;
    tbl_wdata = (state_q == ST_INIT) ? 2'b01 : head_ctr_next;

    pred_valid_d = lookup_fire;
    pred_taken_d = pred_taken_q;
    pred_index_d = pred_index_q;
    pred_hist_d  = pred_hist_q;
    if (lookup_fire) begin
      pred_taken_d = bht_mem[lookup_idx][1];
      pred_index_d = lookup_idx;
      pred_hist_d  = ghr_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      ghr_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      init_busy_q  <= 1'b1;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
      pred_hist_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      ghr_q        <= ghr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      init_busy_q  <= init_busy_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_index_q <= pred_index_d;
      pred_hist_q  <= pred_hist_d;
    end
  end

  // Storage arrays carry no reset: the init walk defines the table and the
  // queue entries are only read while count_q says they are live.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      bht_mem[tbl_waddr] <= tbl_wdata;
    end
    if (upd_fire && !reset) begin
      upq_idx_mem[wr_ptr_q]   <= upd_index;
      upq_taken_mem[wr_ptr_q] <= upd_taken;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_index = pred_index_q;
  assign pred_hist  = pred_hist_q;
  assign init_busy  = init_busy_q;

`ifdef BHT_CTRL_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_lookups_d     = stat_lookups_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (lookup_fire && (stat_lookups_q != 32'hFFFF_FFFF)) begin
      stat_lookups_d = stat_lookups_q + 32'd1;
    end
    if (repair && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
